// File: rtl/ps2_mouse_packet.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_mouse_packet
//  Purpose  : Assembles 3-byte PS/2 mouse movement packets from a received
//             byte stream, checks header framing, decodes buttons and
//             sign-extended X/Y deltas, and hands each packet downstream
//             through a valid/ack handshake. Resyncs on bad headers and on
//             packets that stall between bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_mouse_packet #(
  parameter int OUT_W       = 10,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  input  logic             pkt_ack,
  output logic             pkt_valid,
  output logic             btn_left,
  output logic             btn_right,
  output logic             btn_middle,
  output logic [OUT_W-1:0] dx,
  output logic [OUT_W-1:0] dy,
  output logic             x_ovf,
  output logic             y_ovf,
  output logic             sync_err,
  output logic             timeout_tick,
  output logic             pkt_dropped
);

  // Counter wide enough to hold TIMEOUT_CYC-1 (and never zero bits wide).
  localparam int              c_cnt_w   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    B0 = 2'd0,  // awaiting header byte
    B1 = 2'd1,  // awaiting X byte
    B2 = 2'd2   // awaiting Y byte
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [7:0]         r_byte0;
  logic [7:0]         r_byte1;

  // Packet framing FSM, stall timer and registered packet outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= B0;
      r_cnt        <= '0;
      r_byte0      <= '0;
      r_byte1      <= '0;
      pkt_valid    <= 1'b0;
      btn_left     <= 1'b0;
      btn_right    <= 1'b0;
      btn_middle   <= 1'b0;
      dx           <= '0;
      dy           <= '0;
      x_ovf        <= 1'b0;
      y_ovf        <= 1'b0;
      sync_err     <= 1'b0;
      timeout_tick <= 1'b0;
      pkt_dropped  <= 1'b0;
    end else begin
      // Pulses default low; a completion below overrides the ack clear.
      sync_err     <= 1'b0;
      timeout_tick <= 1'b0;
      pkt_dropped  <= 1'b0;
      if (pkt_ack) begin
        pkt_valid <= 1'b0;
      end

      case (r_state)
        B0: begin
          r_cnt <= '0;
          if (rx_done_tick) begin
            if (rx_data[3]) begin
              r_byte0 <= rx_data;
              r_state <= B1;
            end else begin
              sync_err <= 1'b1;
            end
          end
        end

        B1: begin
          if (rx_done_tick) begin
            r_byte1 <= rx_data;
            r_cnt   <= '0;
            r_state <= B2;
          end else if (r_cnt == c_cnt_max) begin
            r_cnt        <= '0;
            r_state      <= B0;
            timeout_tick <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        B2: begin
          if (rx_done_tick) begin
            r_cnt       <= '0;
            r_state     <= B0;
            pkt_valid   <= 1'b1;
            // Previous packet still pending and not taken this cycle: lost.
            pkt_dropped <= pkt_valid & ~pkt_ack;
            btn_left    <= r_byte0[0];
            btn_right   <= r_byte0[1];
            btn_middle  <= r_byte0[2];
            dx          <= OUT_W'($signed({r_byte0[4], r_byte1}));
            dy          <= OUT_W'($signed({r_byte0[5], rx_data}));
            x_ovf       <= r_byte0[6];
            y_ovf       <= r_byte0[7];
          end else if (r_cnt == c_cnt_max) begin
            r_cnt        <= '0;
            r_state      <= B0;
            timeout_tick <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= B0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_packet.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_mouse_packet
//  Purpose  : Scoreboard bench for ps2_mouse_packet: a byte-level reference
//             model predicts every visible output event, a monitor compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_mouse_packet;

  localparam int OUT_W = 10;
  localparam int T     = 40;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             rx_done_tick = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             pkt_ack = 1'b0;
  logic             pkt_valid, btn_left, btn_right, btn_middle;
  logic [OUT_W-1:0] dx, dy;
  logic             x_ovf, y_ovf, sync_err, timeout_tick, pkt_dropped;

  ps2_mouse_packet #(.OUT_W(OUT_W), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset_n(reset_n), .rx_done_tick(rx_done_tick),
    .rx_data(rx_data), .pkt_ack(pkt_ack), .pkt_valid(pkt_valid),
    .btn_left(btn_left), .btn_right(btn_right), .btn_middle(btn_middle),
    .dx(dx), .dy(dy), .x_ovf(x_ovf), .y_ovf(y_ovf), .sync_err(sync_err),
    .timeout_tick(timeout_tick), .pkt_dropped(pkt_dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int               cyc;
    bit               valid;
    bit [2:0]         btn;   // {middle, right, left}
    bit [OUT_W-1:0]   dx;
    bit [OUT_W-1:0]   dy;
    bit [1:0]         ovf;   // {y, x}
    bit               se;
    bit               to;
    bit               pd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: bytes of the partial packet, idle clocks since the
  // last accepted byte, and the packet currently offered downstream.
  logic [7:0]     pb[$];
  int             idle = 0;
  bit             m_valid = 0;
  bit [2:0]       m_btn = '0;
  bit [OUT_W-1:0] m_dx = '0, m_dy = '0;
  bit [1:0]       m_ovf = '0;

  function automatic bit [OUT_W-1:0] ext9(input bit sign, input logic [7:0] b);
    int          v;
    logic [31:0] w;
    v = int'(b) - (sign ? 256 : 0);
    w = v;
    return w[OUT_W-1:0];
  endfunction

  // One clock of stimulus: drive at the falling edge, predict what the DUT
  // shows after the following rising edge.
  task automatic step(input bit t, input logic [7:0] d, input bit a);
    exp_t r;
    bit   ev = 0, done = 0;
    @(negedge clk);
    rx_done_tick = t; rx_data = d; pkt_ack = a;
    r.cyc = cyc + 1; r.se = 0; r.to = 0; r.pd = 0;
    if (t) begin
      idle = 0;
      if (pb.size() == 0) begin
        if (d[3]) pb.push_back(d);
        else begin ev = 1; r.se = 1; end
      end else if (pb.size() == 1) begin
        pb.push_back(d);
      end else begin
        ev = 1; done = 1;
        r.pd    = m_valid && !a;
        m_valid = 1;
        m_btn   = pb[0][2:0];
        m_dx    = ext9(pb[0][4], pb[1]);
        m_dy    = ext9(pb[0][5], d);
        m_ovf   = {pb[0][7], pb[0][6]};
        pb.delete();
      end
    end else if (pb.size() > 0) begin
      idle++;
      if (idle == T) begin ev = 1; r.to = 1; pb.delete(); idle = 0; end
    end
    if (!done && a && m_valid) begin m_valid = 0; ev = 1; end
    if (ev) begin
      r.valid = m_valid; r.btn = m_btn; r.dx = m_dx; r.dy = m_dy; r.ovf = m_ovf;
      sb.push_back(r);
    end
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input bit ack_last);
    step(1, a, 0); step(1, b, 0); step(1, c, ack_last);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 0; rx_done_tick = 0; pkt_ack = 0;
    pb.delete(); idle = 0; m_valid = 0;
    m_btn = '0; m_dx = '0; m_dy = '0; m_ovf = '0;
    #1;
    vectors++;
    if ({pkt_valid, btn_left, btn_right, btn_middle, dx, dy, x_ovf, y_ovf,
         sync_err, timeout_tick, pkt_dropped} != '0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b btn=%b%b%b dx=%h dy=%h ovf=%b%b se=%b to=%b pd=%b, required all zero",
               pkt_valid, btn_middle, btn_right, btn_left, dx, dy, y_ovf, x_ovf,
               sync_err, timeout_tick, pkt_dropped);
    end
    repeat (n) @(negedge clk);
    reset_n = 1;
  endtask

  // Monitor: compares scheduled events; on quiet cycles requires no pulses
  // and a stable offered packet.
  bit             l_valid = 0;
  bit [2:0]       l_btn = '0;
  bit [OUT_W-1:0] l_dx = '0, l_dy = '0;
  bit [1:0]       l_ovf = '0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        l_valid = 0;
      end else begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          vectors++; miscompares++;
          $display("FAIL stale_event: expected event at cycle %0d never matched (now %0d)", e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          e = sb.pop_front();
          vectors++;
          if (pkt_valid !== e.valid || sync_err !== e.se || timeout_tick !== e.to ||
              pkt_dropped !== e.pd ||
              (e.valid && ({btn_middle, btn_right, btn_left} !== e.btn || dx !== e.dx ||
                           dy !== e.dy || {y_ovf, x_ovf} !== e.ovf))) begin
            miscompares++;
            $display("FAIL event@%0d: actual v=%b btn=%b dx=%h dy=%h ovf=%b se=%b to=%b pd=%b required v=%b btn=%b dx=%h dy=%h ovf=%b se=%b to=%b pd=%b",
                     cyc, pkt_valid, {btn_middle, btn_right, btn_left}, dx, dy, {y_ovf, x_ovf},
                     sync_err, timeout_tick, pkt_dropped, e.valid, e.btn, e.dx, e.dy, e.ovf,
                     e.se, e.to, e.pd);
          end
          l_valid = e.valid; l_btn = e.btn; l_dx = e.dx; l_dy = e.dy; l_ovf = e.ovf;
        end else begin
          vectors++;
          if (sync_err !== 1'b0 || timeout_tick !== 1'b0 || pkt_dropped !== 1'b0 ||
              pkt_valid !== l_valid ||
              (l_valid && ({btn_middle, btn_right, btn_left} !== l_btn || dx !== l_dx ||
                           dy !== l_dy || {y_ovf, x_ovf} !== l_ovf))) begin
            miscompares++;
            $display("FAIL quiet@%0d: actual v=%b dx=%h dy=%h se=%b to=%b pd=%b required v=%b dx=%h dy=%h no pulses",
                     cyc, pkt_valid, dx, dy, sync_err, timeout_tick, pkt_dropped,
                     l_valid, l_dx, l_dy);
          end
        end
      end
    end
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    int gap;
    do_reset(3);
    idle_n(2);
    send3(8'h09, 8'h05, 8'hFB, 0);          // left button, dx=+5, dy=+251
    idle_n(3);
    send3(8'h38, 8'h10, 8'hF0, 0);          // dx=-240, dy=-16 (overwrites)
    idle_n(2);
    step(0, 8'h00, 1); idle_n(2);           // ack clears valid
    step(0, 8'h00, 1); idle_n(1);           // ack with nothing pending
    step(1, 8'h00, 0); idle_n(1);           // bad header -> sync_err
    send3(8'h08, 8'h01, 8'h02, 0);
    idle_n(2);
    step(0, 8'h00, 1);
    step(1, 8'h08, 0); step(1, 8'h01, 0);   // stall a full timeout window
    idle_n(T);
    send3(8'h08, 8'h03, 8'h04, 0);
    step(1, 8'h08, 0); idle_n(T - 1);       // gaps of T-1 idles are tolerated
    step(1, 8'h05, 0); idle_n(T - 1);
    step(1, 8'h06, 0); idle_n(2);
    send3(8'hC9, 8'h7F, 8'h80, 0);          // overflow bits, no ack -> dropped
    idle_n(1);
    send3(8'h2A, 8'hFF, 8'h01, 1);          // ack on completion -> no drop
    idle_n(2);
    step(1, 8'h08, 0); step(1, 8'h01, 0);
    do_reset(2);                            // reset mid-packet
    send3(8'h08, 8'h07, 8'h00, 0);
    idle_n(2);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        gap = $urandom_range(T - 2, T + 1);
        idle_n(gap);
      end
      step($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 3) == 0);
    end
    idle_n(5);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected events left unmatched, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
